stack_word_sequencer: RTL and testbench
=======================================

Name: stack_word_sequencer

Overview:
- Upstream driver for the 1-bit LIFO stack (ports CLK, data, push, pop, D_out).
- Accepts whole words over a valid/ready write interface and serialises them into the stack with one push per bit.
- On a read request, pops one word's worth of bits and reassembles them, so the word is returned in its original bit order.
- Tracks stack occupancy so the stack is never pushed when full or popped when empty.

Parameters:
- WORD_W, 4, bits per word transferred.
- STACK_DEPTH, 8, capacity of the attached stack in bits.
- CNT_W, $clog2(STACK_DEPTH+1), derived localparam, width of the occupancy counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  block can accept a write word this cycle.
- wr_data  in  WORD_W  word to push.
- rd_req  in  1  request to pop one word.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- rd_data  out  WORD_W  last word read.
- stk_push  out  1  drives stack push.
- stk_pop  out  1  drives stack pop.
- stk_data  out  1  drives stack data.
- stk_dout  in  1  stack D_out.
- level  out  CNT_W  bits currently held in the stack.
- full  out  1  level == STACK_DEPTH.
- empty  out  1  level == 0.
- err  out  1  sticky underflow flag.

Behaviour:
- Clock and reset: one clock domain (CLK). RST_N is asynchronous, active-low.
- Reset values:
  - state IDLE; level 0.
  - rd_data 0; rd_valid 0; err 0.
  - stk_push, stk_pop and stk_data all 0.
  - empty 1; full 0.
  - wr_ready 1 once RST_N is released.
- Stack timing contract: stk_pop high in cycle k → the popped bit appears on stk_dout during cycle k+1.
- FSM states: IDLE, PUSH, POP, DRAIN.
- IDLE:
  - wr_ready = (level + WORD_W <= STACK_DEPTH).
  - Read has priority: if rd_req is high and level >= WORD_W, go to POP; in that cycle wr_ready = 0.
  - Else if wr_valid && wr_ready: latch wr_data, go to PUSH.
  - rd_req with level < WORD_W: no pop, err set to 1 (sticky until reset); any write in the same cycle is still accepted.
- PUSH:
  - Lasts exactly WORD_W cycles; stk_push = 1 throughout.
  - stk_data = latched word bit i in cycle i, LSB first.
  - level increments by 1 each cycle. Then IDLE.
- POP:
  - Lasts exactly WORD_W cycles; stk_pop = 1 throughout.
  - level decrements by 1 each cycle. Then DRAIN.
- Capture:
  - The bit popped in POP cycle k is captured at the end of cycle k+1 into shift-register position WORD_W-1-k.
  - The first popped bit (last pushed, the MSB) lands in the MSB position.
- DRAIN:
  - One cycle; captures the final bit.
  - Next cycle: rd_data = assembled word, rd_valid = 1 for one cycle, state IDLE.
  - Read latency: rd_valid high WORD_W+1 cycles after the first stk_pop cycle.
- Holding behaviour:
  - rd_data holds its value until the next completed read.
  - rd_req and wr_valid are ignored outside IDLE, with no error.
  - rd_req held high gives back-to-back reads, with one IDLE cycle between them.
- Invariants:
  - stk_push and stk_pop are never high together.
  - stk_data = 0 whenever stk_push = 0.
  - level never exceeds STACK_DEPTH and never goes below 0.
- Reset mid-operation:
  - Outputs drop asynchronously; level returns to 0.
  - Any partial word is discarded.
  - Stale stack contents are treated as empty and are overwritten by later pushes.

Decomposition:
- Package stack_seq_pkg: state enum typedef (IDLE, PUSH, POP, DRAIN) and default constants WORD_W=4, STACK_DEPTH=8.
- One sub-module, stack_level_counter: an up/down occupancy counter that generates level, full and empty, with asynchronous active-low reset.
- The bit index counter and shift register stay in the top module.

Test Plan (WORD_W=4, STACK_DEPTH=8; bench contains a behavioural 8-deep 1-bit stack model with the stated timing):
- Reset: assert RST_N=0, then release → all outputs 0 except empty=1; wr_ready=1.
- Write 4'hA:
  - → stk_push high 4 cycles.
  - → stk_data sequence 0,1,0,1.
  - → level 4; wr_ready stays 1.
- Write 4'h5, then rd_req:
  - → first read: stk_pop high 4 cycles, rd_valid pulse 5 cycles after the first pop, rd_data=4'h5.
  - → second read: rd_data=4'hA, level 0, empty=1, err=0.
- Full and backpressure: write 4'h3 and 4'hC → level 8, full=1. A third wr_valid → wr_ready=0, no stk_push.
- Underflow: rd_req at level 0 → no stk_pop, rd_valid stays 0, err=1 and stays 1. Simultaneous wr_valid/rd_req at level 4 → pop occurs first.
- Reset mid-PUSH after 2 bits → stk_push falls without waiting for a clock edge; level=0; a subsequent write/read of 4'h9 returns 4'h9.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack word sequencer.
//   seq_state_t          : sequencer FSM states
//   DEFAULT_WORD_W       : default bits per transferred word
//   DEFAULT_STACK_DEPTH  : default capacity of the attached 1-bit stack
package stack_seq_pkg;

  localparam int unsigned DEFAULT_WORD_W      = 4;
  localparam int unsigned DEFAULT_STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    POP,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/stack_level_counter.sv
// Up/down occupancy counter for the attached 1-bit stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : one bit pushed / popped this cycle
//   level      : bits currently held
//   full       : level == DEPTH
//   empty      : level == 0
module stack_level_counter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (inc && !dec && !full) begin
      level <= level + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      level <= level - CNT_W'(1);
    end
  end

  assign full  = (level == CNT_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/stack_word_sequencer.sv
// Word-wide front end for a 1-bit LIFO stack: serialises written words into
// the stack LSB first and pops/reassembles them back in original bit order.
//   CLK, RST_N         : clock, asynchronous active-low reset
//   wr_valid/ready/data: word write handshake
//   rd_req             : pop one word
//   rd_valid, rd_data  : one-cycle completion pulse, last word read
//   stk_push/pop/data  : stack control, stk_dout : stack output (1-cycle latency)
//   level, full, empty : stack occupancy in bits
//   err                : sticky read-underflow flag
module stack_word_sequencer
  import stack_seq_pkg::*;
#(
  parameter  int unsigned WORD_W      = DEFAULT_WORD_W,
  parameter  int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH,
  localparam int unsigned CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_data,
  input  logic              stk_dout,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  seq_state_t        state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_nxt;
  logic              last_bit;
  logic              can_pop;
  logic              can_push;
  logic              rd_go;

  assign last_bit  = (idx == IDX_W'(WORD_W - 1));
  assign can_pop   = (32'(level) >= WORD_W);
  assign can_push  = (32'(level) + WORD_W <= STACK_DEPTH);
  assign rd_go     = rd_req && can_pop;
  // Popped bits arrive one cycle late; first arrival ends up in the MSB.
  assign shift_nxt = (shift_q << 1) | WORD_W'(stk_dout);

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_data  = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = can_push && !rd_go;
        if (rd_go) begin
          state_nxt = POP;
        end else if (wr_valid && wr_ready) begin
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        stk_push = 1'b1;
        stk_data = word_q[idx];
        if (last_bit) state_nxt = IDLE;
      end
      POP: begin
        stk_pop = 1'b1;
        if (last_bit) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      idx      <= '0;
      word_q   <= '0;
      shift_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      if (state == IDLE && wr_valid && wr_ready) word_q <= wr_data;
      if (state == IDLE && rd_req && !can_pop)   err    <= 1'b1;
      if (state == PUSH || state == POP) begin
        idx <= last_bit ? '0 : idx + IDX_W'(1);
      end else begin
        idx <= '0;
      end
      // Capture trails the pop by one cycle: POP cycles 1..W-1 and DRAIN.
      if ((state == POP && idx != '0) || state == DRAIN) shift_q <= shift_nxt;
      if (state == DRAIN) begin
        rd_data  <= shift_nxt;
        rd_valid <= 1'b1;
      end
    end
  end

  stack_level_counter #(
    .DEPTH (STACK_DEPTH),
    .CNT_W (CNT_W)
  ) u_level (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (stk_push),
    .dec   (stk_pop),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_stack_word_sequencer.sv
module tb_stack_word_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_data;
  logic       rd_req;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       stk_push;
  logic       stk_pop;
  logic       stk_data;
  logic       stk_dout;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  stack_word_sequencer #(
    .WORD_W      (4),
    .STACK_DEPTH (8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_data (stk_data),
    .stk_dout (stk_dout),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .err      (err)
  );

  // Behavioural 8-deep 1-bit stack: popped bit visible the cycle after pop.
  logic       mem [8];
  logic [3:0] sp = '0;
  initial stk_dout = 1'b0;
  always @(posedge CLK) begin
    if (stk_push && sp < 4'd8) begin
      mem[sp[2:0]] <= stk_data;
      sp           <= sp + 4'd1;
    end else if (stk_pop && sp > 4'd0) begin
      stk_dout <= mem[3'(sp - 4'd1)];
      sp       <= sp - 4'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Invariants sampled every falling edge outside reset.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (stk_push && stk_pop) begin
        errors++;
        $display("FAIL push_pop_overlap at %0t", $time);
      end
      if (!stk_push && stk_data) begin
        errors++;
        $display("FAIL stk_data_idle: got 1 expected 0 at %0t", $time);
      end
      if (level > 4'd8) begin
        errors++;
        $display("FAIL level_range: got %0d expected <=8 at %0t", level, $time);
      end
    end
  end

  // Called at a falling edge with the DUT idle and room for a word.
  task automatic do_write(input logic [3:0] d, input string nm);
    wr_valid = 1'b1;
    wr_data  = d;
    #1;
    chk({nm, " wr_ready"}, 32'(wr_ready), 32'd1);
    @(negedge CLK);
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({nm, " stk_push"}, 32'(stk_push), 32'd1);
      chk({nm, " stk_data"}, 32'(stk_data), 32'(d[i]));
      @(negedge CLK);
    end
    chk({nm, " push_end"}, 32'(stk_push), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] exp, input string nm);
    int cyc;
    int pops;
    rd_req = 1'b1;
    #1;
    chk({nm, " wr_ready_on_read"}, 32'(wr_ready), 32'd0);
    @(negedge CLK);
    rd_req = 1'b0;
    cyc  = 0;
    pops = 0;
    while (!rd_valid && cyc < 12) begin
      if (stk_pop) pops++;
      @(negedge CLK);
      cyc++;
    end
    chk({nm, " pop_count"}, 32'(pops), 32'd4);
    chk({nm, " latency"}, 32'(cyc), 32'd5);
    chk({nm, " rd_data"}, 32'(rd_data), 32'(exp));
    @(negedge CLK);
    chk({nm, " rd_valid_pulse"}, 32'(rd_valid), 32'd0);
  endtask

  typedef struct {
    bit         is_read;
    logic [3:0] data;
    logic [3:0] exp_level;
    bit         exp_full;
    bit         exp_empty;
    bit         exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    vecs[0] = '{1'b0, 4'hA, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'h5, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'h5, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'hA, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'h3, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'hC, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 4'hC, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'h3, 4'd0, 1'b0, 1'b1, 1'b0};

    RST_N    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    #3;
    chk("rst rd_valid", 32'(rd_valid), 32'd0);
    chk("rst rd_data", 32'(rd_data), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst stk_push", 32'(stk_push), 32'd0);
    chk("rst stk_pop", 32'(stk_pop), 32'd0);
    chk("rst stk_data", 32'(stk_data), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst wr_ready", 32'(wr_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_read) do_read(vecs[i].data, $sformatf("vec%0d", i));
      else                 do_write(vecs[i].data, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      if (i == 5) begin
        // Backpressure at full: write offered but must not be taken.
        wr_valid = 1'b1;
        wr_data  = 4'hF;
        #1;
        chk("full wr_ready", 32'(wr_ready), 32'd0);
        repeat (3) begin
          @(negedge CLK);
          chk("full no_push", 32'(stk_push), 32'd0);
          chk("full level", 32'(level), 32'd8);
        end
        wr_valid = 1'b0;
      end
    end

    // Underflow: read at level 0 never pops and sets sticky err.
    rd_req = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("uflow no_pop", 32'(stk_pop), 32'd0);
      chk("uflow rd_valid", 32'(rd_valid), 32'd0);
    end
    rd_req = 1'b0;
    chk("uflow err", 32'(err), 32'd1);
    @(negedge CLK);
    chk("uflow err_sticky", 32'(err), 32'd1);

    // Simultaneous write and read at level 4: read wins.
    do_write(4'h6, "pre_sim");
    wr_valid = 1'b1;
    wr_data  = 4'h7;
    rd_req   = 1'b1;
    #1;
    chk("sim wr_ready", 32'(wr_ready), 32'd0);
    @(negedge CLK);
    rd_req = 1'b0;
    chk("sim pop_first", 32'(stk_pop), 32'd1);
    chk("sim no_push", 32'(stk_push), 32'd0);
    cyc = 0;
    while (!rd_valid && cyc < 12) begin
      @(negedge CLK);
      cyc++;
    end
    chk("sim latency", 32'(cyc), 32'd5);
    chk("sim rd_data", 32'(rd_data), 32'h6);
    @(negedge CLK);
    wr_valid = 1'b0;
    chk("sim push_after", 32'(stk_push), 32'd1);
    repeat (4) @(negedge CLK);
    chk("sim level", 32'(level), 32'd4);
    do_read(4'h7, "sim_rd2");
    chk("sim err_still", 32'(err), 32'd1);

    // Reset in the middle of a push after two bits.
    wr_valid = 1'b1;
    wr_data  = 4'hB;
    @(negedge CLK);
    wr_valid = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst stk_push", 32'(stk_push), 32'd0);
    chk("midrst level", 32'(level), 32'd0);
    chk("midrst empty", 32'(empty), 32'd1);
    chk("midrst err", 32'(err), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    do_write(4'h9, "post_rst_wr");
    chk("post_rst level4", 32'(level), 32'd4);
    do_read(4'h9, "post_rst_rd");
    chk("post_rst level0", 32'(level), 32'd0);
    chk("post_rst err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
